// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared encodings and helpers for the EX-stage divider.
//   - div_state_e : sequencer states (2-bit encoding)
//   - DIV_START/DIV_STOP, DIV_RESULT_READY/DIV_RESULT_NOT_READY : handshake levels
//   - DIV_ITERS   : number of restoring iterations (one quotient bit each)
//   - div_mag()   : operand magnitude for signed/unsigned division
package div_ctrl_pkg;

  localparam int REG_W  = 32;
  localparam int DREG_W = 64;

  typedef enum logic [1:0] {
    DIV_FREE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;

  localparam logic       DIV_START            = 1'b1;
  localparam logic       DIV_STOP             = 1'b0;
  localparam logic       DIV_RESULT_READY     = 1'b1;
  localparam logic       DIV_RESULT_NOT_READY = 1'b0;
  localparam logic [5:0] DIV_ITERS            = 6'd32;

  // Two's-complement magnitude when the operation is signed and the operand
  // is negative; 0x80000000 maps onto itself, which is its correct unsigned
  // magnitude.
  function automatic logic [REG_W-1:0] div_mag(input logic sgn, input logic [REG_W-1:0] op);
    return (sgn && op[REG_W-1]) ? (~op + 32'd1) : op;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration.
//   sreg_i  [63:0] : low 64 bits of the {rem[64:32], dvd[31:0]} register
//                    (rem[64] is always 0 between iterations since rem < divisor)
//   divisor_i[31:0]: divisor magnitude
//   sreg_o  [64:0] : next register value, quotient bit shifted into bit 0
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [63:0]      sreg_i,
  input  logic [REG_W-1:0] divisor_i,
  output logic [64:0]      sreg_o
);

  logic [64:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted = {sreg_i, 1'b0};
    diff    = shifted[64:32] - {1'b0, divisor_i};
    // diff[32] set means the partial remainder was smaller than the divisor
    if (!diff[32]) sreg_o = {diff, shifted[31:1], 1'b1};
    else           sreg_o = shifted;
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU sequencer for the EX stage.
// Restoring division, one quotient bit per cycle, {remainder, quotient} out.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   signed_div_i      : 1 = signed division; sampled with start_i
//   opdata1_i/2_i     : dividend / divisor; sampled with start_i
//   start_i           : request, held by EX until ready_o
//   annul_i           : flush; aborts an in-flight division
//   result_o[63:0]    : {remainder, quotient}, valid while ready_o
//   ready_o           : result valid
//   busy_o            : high while in DIV_ZERO or DIV_ON
// Optional feature: define DIV_EARLY_OUT_EN to finish |op1| < |op2| divisions
// without iterating (same 2-edge latency as divide-by-zero).
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_div_i,
  input  logic [REG_W-1:0]  opdata1_i,
  input  logic [REG_W-1:0]  opdata2_i,
  input  logic              start_i,
  input  logic              annul_i,
  output logic [DREG_W-1:0] result_o,
  output logic              ready_o,
  output logic              busy_o
);

  div_state_e        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [64:0]       sreg_q, sreg_d;
  logic [REG_W-1:0]  div_q, div_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [DREG_W-1:0] result_q, result_d;
  logic              ready_q, ready_d;

  logic [64:0]       step_next;
  logic [REG_W-1:0]  mag1, mag2, quo, rem;
  logic              unused_sreg_top;

  assign mag1 = div_mag(signed_div_i, opdata1_i);
  assign mag2 = div_mag(signed_div_i, opdata2_i);

  div_step u_step (
    .sreg_i    (sreg_q[63:0]),
    .divisor_i (div_q),
    .sreg_o    (step_next)
  );

  // Remainder never exceeds 32 bits once iterations finish.
  assign unused_sreg_top = sreg_q[64];

  assign quo = negq_q ? (~sreg_q[31:0] + 32'd1)  : sreg_q[31:0];
  assign rem = negr_q ? (~sreg_q[63:32] + 32'd1) : sreg_q[63:32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    div_d    = div_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            // Remainder field doubles as the value DIV_ZERO publishes.
            state_d = DIV_ZERO;
            sreg_d  = '0;
`ifdef DIV_EARLY_OUT_EN
          end else if (mag1 < mag2) begin
            // Quotient 0, remainder is the original dividend; reuse the
            // DIV_ZERO hop so ready timing matches the divide-by-zero path.
            state_d = DIV_ZERO;
            sreg_d  = {1'b0, opdata1_i, 32'h0};
`endif
          end else begin
            state_d = DIV_ON;
            cnt_d   = '0;
            sreg_d  = {33'h0, mag1};
            div_d   = mag2;
            negq_d  = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            negr_d  = signed_div_i & opdata1_i[31];
          end
        end
      end

      DIV_ZERO: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          result_d = {sreg_q[63:32], 32'h0};
          ready_d  = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
          cnt_d   = '0;
        end else if (cnt_q != DIV_ITERS) begin
          sreg_d = step_next;
          cnt_d  = cnt_q + 6'd1;
        end else begin
          state_d  = DIV_END;
          cnt_d    = '0;
          result_d = {rem, quo};
          ready_d  = DIV_RESULT_READY;
        end
      end

      DIV_END: begin
        // annul_i deliberately ignored: the result is already committed.
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end

      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      div_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      div_q    <= div_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == DIV_ZERO) || (state_q == DIV_ON);

endmodule
